// File: rtl/load_pkg.sv
// load_pkg: shared constants for the RV32I load sequencer.
//   - LOAD opcode value
//   - funct3 encodings for the five supported load widths
//   - sequencer state encodings
package load_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_REQ  = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  // True for funct3 codes that are not a defined load width.
  function automatic logic f3_is_illegal(input logic [2:0] f3);
    logic bad;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: bad = 1'b0;
      default:                              bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// load_align_ext: picks the byte/half lane of a little-endian memory word
// and sign- or zero-extends it to 32 bits.
//   funct3  in  3   load width/signedness
//   off     in  2   effective address bits [1:0]
//   word    in  32  raw memory word
//   result  out 32  extended load value (0 for undefined funct3)
// Halfwords use off[1] only and words ignore off entirely, so a misaligned
// access that is not trapped still returns the naturally aligned container.
module load_align_ext
  import load_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection from the low address bits.
  always_comb begin
    byte_s = 8'h00;
    case (off)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (off[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Width and sign/zero extension.
  always_comb begin
    result = 32'h0000_0000;
    case (funct3)
      F3_LB:   result = {{24{byte_s[7]}}, byte_s};
      F3_LH:   result = {{16{half_s[15]}}, half_s};
      F3_LW:   result = word;
      F3_LBU:  result = {24'h00_0000, byte_s};
      F3_LHU:  result = {16'h0000, half_s};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_seq_ctrl.sv
// load_seq_ctrl: multi-cycle sequencer for RV32I I-type loads.
// Accepts an instruction word, reads rs1, forms eff = rs1 + sext(imm),
// issues one valid/ready memory request, aligns/extends the response and
// performs a single write-back to rd.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/ready/word   instruction handshake (ready only in IDLE)
//   rf_rs1_addr/rf_rs1_data  register-file read port (combinational data)
//   mem_req_valid/ready      memory request handshake, mem_addr word-aligned
//   mem_resp_valid/data      memory response (only sampled in WAIT)
//   wb_en/wb_rd/wb_data      one-cycle write-back (suppressed for rd == 0)
//   err_illegal/err_misalign one-cycle error pulses
// Build option: define MISALIGN_TRAP_EN to trap misaligned LH/LHU/LW with
// err_misalign; otherwise err_misalign stays 0 and offsets are truncated.
module load_seq_ctrl
  import load_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr_word,
  output logic [4:0]  rf_rs1_addr,
  input  logic [31:0] rf_rs1_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_illegal,
  output logic        err_misalign
);

  logic [2:0]  state_r;
  logic [11:0] imm_r;
  logic [2:0]  funct3_r;
  logic [4:0]  rd_r;
  logic [6:0]  opcode_r;
  logic [1:0]  off_r;

  logic [31:0] eff_s;
  logic        illegal_s;
  logic        misalign_s;
  logic [31:0] load_data_s;

  // Effective address and decode checks, evaluated while in ADDR.
  always_comb begin
    eff_s     = rf_rs1_data + {{20{imm_r[11]}}, imm_r};
    illegal_s = 1'b0;
    if (opcode_r != OPC_LOAD) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = f3_is_illegal(funct3_r);
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Natural-alignment check for half and word accesses.
  always_comb begin
    misalign_s = 1'b0;
    case (funct3_r)
      F3_LH, F3_LHU: misalign_s = eff_s[0];
      F3_LW:         misalign_s = |eff_s[1:0];
      default:       misalign_s = 1'b0;
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  load_align_ext u_align (
    .funct3 (funct3_r),
    .off    (off_r),
    .word   (mem_resp_data),
    .result (load_data_s)
  );

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      instr_ready   <= 1'b1;
      rf_rs1_addr   <= 5'd0;
      mem_req_valid <= 1'b0;
      mem_addr      <= 32'h0000_0000;
      wb_en         <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= 32'h0000_0000;
      err_illegal   <= 1'b0;
      err_misalign  <= 1'b0;
      imm_r         <= 12'h000;
      funct3_r      <= 3'b000;
      rd_r          <= 5'd0;
      opcode_r      <= 7'd0;
      off_r         <= 2'd0;
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      wb_en        <= 1'b0;
      err_illegal  <= 1'b0;
      err_misalign <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (instr_valid) begin
            opcode_r    <= instr_word[6:0];
            rd_r        <= instr_word[11:7];
            funct3_r    <= instr_word[14:12];
            rf_rs1_addr <= instr_word[19:15];
            imm_r       <= instr_word[31:20];
            instr_ready <= 1'b0;
            state_r     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (illegal_s) begin
            err_illegal <= 1'b1;
            state_r     <= ST_ERR;
          end else if (misalign_s) begin
            err_misalign <= 1'b1;
            state_r      <= ST_ERR;
          end else begin
            mem_addr      <= {eff_s[31:2], 2'b00};
            off_r         <= eff_s[1:0];
            mem_req_valid <= 1'b1;
            state_r       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_r       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            wb_rd   <= rd_r;
            wb_data <= load_data_s;
            wb_en   <= (rd_r != 5'd0);
            state_r <= ST_WB;
          end
        end
        ST_WB: begin
          instr_ready <= 1'b1;
          state_r     <= ST_IDLE;
        end
        ST_ERR: begin
          instr_ready <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          mem_req_valid <= 1'b0;
          instr_ready   <= 1'b1;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_seq_ctrl.sv
// Directed self-checking bench for load_seq_ctrl. Cycle n values are sampled
// 1 time unit after the n-th rising edge following the accept cycle.
module tb_load_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [4:0]  rf_rs1_addr;
  logic [31:0] rf_rs1_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_illegal;
  logic        err_misalign;

  logic [31:0] rf_mem [32];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rf_rs1_data = rf_mem[rf_rs1_addr];

  load_seq_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_word     (instr_word),
    .rf_rs1_addr    (rf_rs1_addr),
    .rf_rs1_data    (rf_rs1_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .wb_en          (wb_en),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .err_illegal    (err_illegal),
    .err_misalign   (err_misalign)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " instr_ready"},   {31'd0, instr_ready},   32'd1);
    check_val({tag, " mem_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
    check_val({tag, " mem_addr"},      mem_addr,               32'h0000_0000);
    check_val({tag, " wb_en"},         {31'd0, wb_en},         32'd0);
    check_val({tag, " wb_rd"},         {27'd0, wb_rd},         32'd0);
    check_val({tag, " wb_data"},       wb_data,                32'h0000_0000);
    check_val({tag, " rf_rs1_addr"},   {27'd0, rf_rs1_addr},   32'd0);
    check_val({tag, " err"},           {30'd0, err_illegal, err_misalign}, 32'd0);
  endtask

  // Full load transaction with the given request and response stall counts.
  task automatic do_load(input string tag, input logic [31:0] instr,
                         input int req_stall, input int resp_stall,
                         input logic [31:0] resp, input logic [31:0] exp_addr,
                         input logic exp_wb, input logic [4:0] exp_rd,
                         input logic [31:0] exp_data);
    check_val({tag, " ready c0"}, {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr_word  = instr;
    step();                                  // cycle 1 (ADDR)
    instr_valid = 1'b0;
    check_val({tag, " rs1 addr c1"}, {27'd0, rf_rs1_addr}, {27'd0, instr[19:15]});
    step();                                  // cycle 2 (REQ)
    check_val({tag, " req_valid c2"}, {31'd0, mem_req_valid}, 32'd1);
    check_val({tag, " mem_addr c2"},  mem_addr, exp_addr);
    for (int i = 0; i < req_stall; i++) begin
      step();
      check_val({tag, " req_valid stall"}, {31'd0, mem_req_valid}, 32'd1);
      check_val({tag, " mem_addr stall"},  mem_addr, exp_addr);
    end
    mem_req_ready = 1'b1;
    step();                                  // WAIT
    mem_req_ready = 1'b0;
    check_val({tag, " req_valid wait"}, {31'd0, mem_req_valid}, 32'd0);
    for (int i = 0; i < resp_stall; i++) begin
      step();
      check_val({tag, " wb_en early"}, {31'd0, wb_en}, 32'd0);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = resp;
    step();                                  // WB
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0000_0000;
    check_val({tag, " wb_en"}, {31'd0, wb_en}, {31'd0, exp_wb});
    if (exp_wb) begin
      check_val({tag, " wb_rd"},   {27'd0, wb_rd}, {27'd0, exp_rd});
      check_val({tag, " wb_data"}, wb_data, exp_data);
    end
    step();                                  // back to IDLE
    check_val({tag, " wb_en off"},   {31'd0, wb_en},       32'd0);
    check_val({tag, " ready again"}, {31'd0, instr_ready}, 32'd1);
  endtask

  // Transaction that must end in an error pulse with no memory activity.
  task automatic do_err(input string tag, input logic [31:0] instr,
                        input logic exp_ill, input logic exp_mis);
    instr_valid = 1'b1;
    instr_word  = instr;
    step();                                  // cycle 1
    instr_valid = 1'b0;
    check_val({tag, " req c1"}, {31'd0, mem_req_valid}, 32'd0);
    step();                                  // cycle 2
    check_val({tag, " err c2"}, {30'd0, err_illegal, err_misalign}, {30'd0, exp_ill, exp_mis});
    check_val({tag, " req c2"}, {31'd0, mem_req_valid}, 32'd0);
    check_val({tag, " ready c2"}, {31'd0, instr_ready}, 32'd0);
    step();                                  // cycle 3
    check_val({tag, " err c3"}, {30'd0, err_illegal, err_misalign}, 32'd0);
    check_val({tag, " ready c3"}, {31'd0, instr_ready}, 32'd1);
    check_val({tag, " req c3"}, {30'd0, mem_req_valid, wb_en}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0000_0000;
    rf_mem[1]  = 32'h0000_0004;
    rf_mem[13] = 32'h0000_0000;
    rf_mem[19] = 32'h0000_1000;

    rst            = 1'b1;
    instr_valid    = 1'b0;
    instr_word     = 32'h0000_0000;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0000_0000;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // LB sign extension, zero-wait memory.
    do_load("lb", {12'b001000001001, 5'd19, 3'b000, 5'd7, 7'b0000011}, 0, 0,
            32'h1234_8056, 32'h0000_1208, 1'b1, 5'd7, 32'hFFFF_FF80);

    // Illegal funct3 and illegal opcode.
    do_err("ill_f3", {12'b011101101101, 5'd1, 3'b111, 5'd6, 7'b0000011}, 1'b1, 1'b0);
    do_err("ill_opc", {12'h004, 5'd1, 3'b010, 5'd6, 7'b0010011}, 1'b1, 1'b0);

    // Misaligned LHU.
`ifdef MISALIGN_TRAP_EN
    do_err("mis_lhu", {12'b000011110101, 5'd13, 3'b101, 5'd13, 7'b0000011}, 1'b0, 1'b1);
`else
    do_load("mis_lhu", {12'b000011110101, 5'd13, 3'b101, 5'd13, 7'b0000011}, 0, 0,
            32'hAABB_CCDD, 32'h0000_00F4, 1'b1, 5'd13, 32'h0000_CCDD);
`endif

    // Backpressure: same LB with 3 request stalls and 2 response stalls.
    do_load("bp", {12'b001000001001, 5'd19, 3'b000, 5'd7, 7'b0000011}, 3, 2,
            32'h1234_8056, 32'h0000_1208, 1'b1, 5'd7, 32'hFFFF_FF80);

    // LW with wrap-around to 0 and rd = 0.
    do_load("wrap", {12'hFFC, 5'd1, 3'b010, 5'd0, 7'b0000011}, 0, 0,
            32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000);

    // LBU / LH / LW lane and extension patterns.
    do_load("lbu", {12'h00B, 5'd19, 3'b100, 5'd9, 7'b0000011}, 0, 1,
            32'h9A12_3456, 32'h0000_1008, 1'b1, 5'd9, 32'h0000_009A);
    do_load("lh_hi", {12'h002, 5'd19, 3'b001, 5'd10, 7'b0000011}, 1, 0,
            32'h8001_7FFF, 32'h0000_1000, 1'b1, 5'd10, 32'hFFFF_8001);
    do_load("lw", {12'h010, 5'd19, 3'b010, 5'd31, 7'b0000011}, 0, 0,
            32'hCAFE_F00D, 32'h0000_1010, 1'b1, 5'd31, 32'hCAFE_F00D);

    // Reset while waiting for the response, then a late response.
    instr_valid = 1'b1;
    instr_word  = {12'b001000001001, 5'd19, 3'b000, 5'd7, 7'b0000011};
    step();
    instr_valid = 1'b0;
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("rst_wait");
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_8056;
    step();
    mem_resp_valid = 1'b0;
    check_val("late resp wb_en", {31'd0, wb_en}, 32'd0);
    check_val("late resp req", {31'd0, mem_req_valid}, 32'd0);
    step();
    check_val("late resp wb_en2", {31'd0, wb_en}, 32'd0);
    do_load("after_rst", {12'h006, 5'd19, 3'b101, 5'd4, 7'b0000011}, 0, 0,
            32'hBEEF_1234, 32'h0000_1004, 1'b1, 5'd4, 32'h0000_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
